// File: rtl/bvurem_inv_search_if.sv
// Request/response bundle for the urem inverse finder: operand request in,
// search result out, each with its own valid/ready handshake.
interface bvurem_inv_search_if #(parameter int W = 4);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_s;
  logic [W-1:0] in_t;
  logic         in_pos;
  logic         in_eq;
  logic         out_valid;
  logic         out_ready;
  logic         out_sat;
  logic [W-1:0] out_x;
  logic [W:0]   out_iters;

  modport master (
    output in_valid, in_s, in_t, in_pos, in_eq, out_ready,
    input  in_ready, out_valid, out_sat, out_x, out_iters
  );
  modport slave (
    input  in_valid, in_s, in_t, in_pos, in_eq, out_ready,
    output in_ready, out_valid, out_sat, out_x, out_iters
  );
endinterface

// File: rtl/bvurem_inv_search.sv
// Sequential search for the smallest x with (x urem s) or (s urem x) related
// to t by == or !=; each candidate is checked with a W-step restoring divider.
module bvurem_inv_search #(
  parameter int W = 4
) (
  input  logic          clk,
  input  logic          rst,
  bvurem_inv_search_if.slave io
);
  localparam int SW = $clog2(W + 1);

  typedef enum logic [2:0] {IDLE, SETUP, DIV, CHECK, DONE} state_e;

  state_e        state_q;
  logic [W-1:0]  s_q, t_q, cand_q, dvd_q, dvs_q;
  logic          pos_q, eq_q;
  logic [W:0]    rem_q;
  logic [SW-1:0] step_q;
  logic          in_ready_q, out_valid_q, out_sat_q;
  logic [W-1:0]  out_x_q;
  logic [W:0]    out_iters_q;

  logic [W:0]    shl, rem_d, rem_fin;
  logic          hit;

  always_comb begin
    shl     = {rem_q[W-1:0], dvd_q[W-1]};
    rem_d   = (shl >= {1'b0, dvs_q}) ? shl - {1'b0, dvs_q} : shl;
    // SMT-LIB: a urem 0 = a, so bypass whatever the divider produced
    rem_fin = (dvs_q == '0) ? {1'b0, (pos_q ? s_q : cand_q)} : rem_q;
    hit     = eq_q ? (rem_fin == {1'b0, t_q}) : (rem_fin != {1'b0, t_q});
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      s_q         <= '0;
      t_q         <= '0;
      cand_q      <= '0;
      dvd_q       <= '0;
      dvs_q       <= '0;
      pos_q       <= 1'b0;
      eq_q        <= 1'b0;
      rem_q       <= '0;
      step_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_sat_q   <= 1'b0;
      out_x_q     <= '0;
      out_iters_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (io.in_valid && in_ready_q) begin
          s_q        <= io.in_s;
          t_q        <= io.in_t;
          pos_q      <= io.in_pos;
          eq_q       <= io.in_eq;
          cand_q     <= '0;
          in_ready_q <= 1'b0;
          state_q    <= SETUP;
        end
        SETUP: begin
          dvd_q   <= pos_q ? s_q : cand_q;
          dvs_q   <= pos_q ? cand_q : s_q;
          rem_q   <= '0;
          step_q  <= '0;
          state_q <= DIV;
        end
        DIV: begin
          rem_q  <= rem_d;
          dvd_q  <= dvd_q << 1;
          step_q <= step_q + 1'b1;
          if (step_q == SW'(W - 1)) state_q <= CHECK;
        end
        CHECK: begin
          if (hit) begin
            out_sat_q   <= 1'b1;
            out_x_q     <= cand_q;
            out_iters_q <= {1'b0, cand_q} + (W+1)'(1);
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end else if (cand_q == '1) begin
            out_sat_q   <= 1'b0;
            out_x_q     <= '0;
            out_iters_q <= {1'b1, {W{1'b0}}};
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end else begin
            cand_q  <= cand_q + 1'b1;
            state_q <= SETUP;
          end
        end
        DONE: if (io.out_ready) begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign io.in_ready  = in_ready_q;
  assign io.out_valid = out_valid_q;
  assign io.out_sat   = out_sat_q;
  assign io.out_x     = out_x_q;
  assign io.out_iters = out_iters_q;
endmodule
